hwpe_stream_tcdm_reorder_ctrl: RTL and testbench

HWPE_STREAM_TCDM_REORDER_CTRL -- requirements
Module: hwpe_stream_tcdm_reorder_ctrl

---
 rtl/hwpe_stream_tcdm_reorder_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_hwpe_stream_tcdm_reorder_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_tcdm_reorder_ctrl.sv
// hwpe_stream_tcdm_reorder_ctrl
// Rotation scheduler for a TCDM channel reorder crossbar. It counts granted
// requests, and after a programmable number of grants it gates new requests.
// It then waits for every outstanding response to come back, and only then
// advances the rotation offset. Because of this, responses always route back
// through the same permutation that issued them.
module hwpe_stream_tcdm_reorder_ctrl #(
   parameter int unsigned NB_CHAN   = 2,
   parameter int unsigned MAX_OUTST = 8,
   parameter int unsigned PERIOD_W  = 8,
   localparam int unsigned CW       = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic                         enable_i,
   input  logic [PERIOD_W-1:0]          period_i,
   input  logic [NB_CHAN-1:0]           tcdm_req_i,
   input  logic [NB_CHAN-1:0]           tcdm_gnt_i,
   input  logic [NB_CHAN-1:0]           tcdm_r_valid_i,
   output logic [NB_CHAN-1:0][CW-1:0]   order_o,
   output logic [CW-1:0]                offset_o,
   output logic                         req_enable_o,
   output logic                         busy_o,
   output logic                         err_o
);

   // grant counter, outstanding counter and per-cycle popcount widths
   localparam int unsigned GW = PERIOD_W + CW;
   localparam int unsigned OW = $clog2(MAX_OUTST + NB_CHAN + 1) + 1;
   localparam int unsigned PW = $clog2(NB_CHAN + 1);
   localparam logic [OW-1:0] OUTST_HI = OW'(MAX_OUTST - NB_CHAN);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_ROTATE = 2'd3
   } state_t;

   state_t              r_state, w_state_next;
   logic [CW-1:0]       r_offset, w_offset_next;
   logic [GW-1:0]       r_gcnt, w_gcnt_next;
   logic [OW-1:0]       r_outst, w_outst_next;
   logic                r_stop_pending, w_stop_pending_next;
   logic                r_err;
   logic [NB_CHAN-1:0][CW-1:0] r_order;
   logic [NB_CHAN-1:0][CW-1:0] w_order_next;

   logic [PW-1:0]       w_hs_cnt;
   logic [PW-1:0]       w_rv_cnt;
   logic [OW-1:0]       w_outst_sum;
   logic                w_underflow;
   logic [GW:0]         w_gcnt_sum;
   logic [GW-1:0]       w_gcnt_add;
   logic                w_period_hit;

   // popcount of handshakes and of returning responses this cycle
   always_comb begin
      w_hs_cnt = '0;
      w_rv_cnt = '0;
      for (int k = 0; k < NB_CHAN; k++) begin
         w_hs_cnt = w_hs_cnt + PW'(tcdm_req_i[k] & tcdm_gnt_i[k]);
         w_rv_cnt = w_rv_cnt + PW'(tcdm_r_valid_i[k]);
      end
   end

   // outstanding tracking with saturation at zero on response underflow
   always_comb begin
      w_outst_sum  = r_outst + OW'(w_hs_cnt);
      w_underflow  = (OW'(w_rv_cnt) > w_outst_sum);
      w_outst_next = w_underflow ? '0 : (w_outst_sum - OW'(w_rv_cnt));
   end

   // grant accumulation; saturates so that a period of 0 never wraps back into a hit
   always_comb begin
      w_gcnt_sum   = {1'b0, r_gcnt} + (GW + 1)'(w_hs_cnt);
      w_gcnt_add   = w_gcnt_sum[GW] ? '1 : w_gcnt_sum[GW-1:0];
      // only a handshake cycle can trigger, so lowering period_i acts on the next grant
      w_period_hit = (period_i != '0) && (w_hs_cnt != '0) &&
                     (w_gcnt_add >= GW'(period_i));
   end

   // next-state and next-register logic of the rotation FSM
   always_comb begin
      w_state_next        = r_state;
      w_offset_next       = r_offset;
      w_gcnt_next         = r_gcnt;
      w_stop_pending_next = r_stop_pending;
      unique case (r_state)
         ST_IDLE: begin
            w_gcnt_next = '0;
            if (enable_i) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_gcnt_next = w_gcnt_add;
            // a stop request wins over a coincident period hit
            if (!enable_i) begin
               w_state_next        = ST_DRAIN;
               w_stop_pending_next = 1'b1;
            end else if (w_period_hit) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // late handshakes still land in the outstanding count, never in the grant count
            if (w_outst_next == '0) begin
               if (r_stop_pending) begin
                  w_state_next        = ST_IDLE;
                  w_stop_pending_next = 1'b0;
                  w_gcnt_next         = '0;
               end else begin
                  w_state_next = ST_ROTATE;
               end
            end
         end
         ST_ROTATE: begin
            // channel count is a power of two, so the natural wrap gives the modulo
            w_offset_next = r_offset + CW'(1);
            w_gcnt_next   = '0;
            w_state_next  = ST_RUN;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // static reorder select computed from the next offset, so order_o comes straight off flops
   for (genvar gi = 0; gi < NB_CHAN; gi++) begin : g_order
      assign w_order_next[gi] = CW'(gi) + w_offset_next;
   end

   // state and counter registers; clear_i overrides every other update
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state        <= ST_IDLE;
         r_offset       <= '0;
         r_gcnt         <= '0;
         r_outst        <= '0;
         r_stop_pending <= 1'b0;
         r_err          <= 1'b0;
      end else if (clear_i) begin
         r_state        <= ST_IDLE;
         r_offset       <= '0;
         r_gcnt         <= '0;
         r_outst        <= '0;
         r_stop_pending <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_offset       <= w_offset_next;
         r_gcnt         <= w_gcnt_next;
         r_outst        <= w_outst_next;
         r_stop_pending <= w_stop_pending_next;
         r_err          <= r_err | w_underflow;
      end
   end

   // per-channel order registers, identity after reset or clear
   for (genvar gi = 0; gi < NB_CHAN; gi++) begin : g_order_reg
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_order[gi] <= CW'(gi);
         end else if (clear_i) begin
            r_order[gi] <= CW'(gi);
         end else begin
            r_order[gi] <= w_order_next[gi];
         end
      end
   end

   // output decode: requests open in IDLE/RUN unless the outstanding window is nearly full
   always_comb begin
      req_enable_o = 1'b0;
      unique case (r_state)
         ST_IDLE, ST_RUN: req_enable_o = (r_outst <= OUTST_HI);
         default:         req_enable_o = 1'b0;
      endcase
      busy_o   = (r_state != ST_IDLE);
      err_o    = r_err;
      offset_o = r_offset;
      order_o  = r_order;
   end

endmodule

// File: tb/tb_hwpe_stream_tcdm_reorder_ctrl.sv
// Directed bench for hwpe_stream_tcdm_reorder_ctrl (4 channels, 8 outstanding).
// The driver pushes the hand-computed post-edge expectation of every cycle into
// a queue. The monitor pops one entry after each rising edge and compares it.
module tb_hwpe_stream_tcdm_reorder_ctrl;

   localparam int NB = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            clear;
   logic            enable;
   logic [7:0]      period;
   logic [NB-1:0]   req, gnt, rvalid;
   logic [NB-1:0][1:0] order;
   logic [1:0]      offset;
   logic            req_en, busy, err;

   typedef struct {
      int id;
      int off;
      int ren;
      int bsy;
      int er;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;
   int   step_id = 0;

   always #5 clk = ~clk;

   hwpe_stream_tcdm_reorder_ctrl #(
      .NB_CHAN   (NB),
      .MAX_OUTST (8),
      .PERIOD_W  (8)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .clear_i        (clear),
      .enable_i       (enable),
      .period_i       (period),
      .tcdm_req_i     (req),
      .tcdm_gnt_i     (gnt),
      .tcdm_r_valid_i (rvalid),
      .order_o        (order),
      .offset_o       (offset),
      .req_enable_o   (req_en),
      .busy_o         (busy),
      .err_o          (err)
   );

   function automatic void cmp(string nm, int id, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %0d expected %0d", nm, id, act, exp);
      end
   endfunction

   function automatic void check_all(int id, int off, int ren, int bsy, int er);
      cmp("offset", id, int'(offset), off);
      cmp("req_enable", id, int'(req_en), ren);
      cmp("busy", id, int'(busy), bsy);
      cmp("err", id, int'(err), er);
      for (int i = 0; i < NB; i++) begin
         cmp($sformatf("order[%0d]", i), id, int'(order[i]), (i + off) % NB);
      end
   endfunction

   // monitor: one expectation per clock, compared just after the edge
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         $display("step %0d: off=%0d req_en=%0d busy=%0d err=%0d",
                  mon_e.id, offset, req_en, busy, err);
         check_all(mon_e.id, mon_e.off, mon_e.ren, mon_e.bsy, mon_e.er);
      end
   end

   // drive one cycle of stimulus and queue the state expected after the edge
   task automatic step(input logic en, input logic clr, input logic [7:0] per,
                       input logic [NB-1:0] rq, input logic [NB-1:0] gn,
                       input logic [NB-1:0] rv,
                       input int o, input int ren, input int bsy, input int er);
      exp_t e;
      @(negedge clk);
      enable = en; clear = clr; period = per;
      req = rq; gnt = gn; rvalid = rv;
      step_id++;
      e.id = step_id; e.off = o; e.ren = ren; e.bsy = bsy; e.er = er;
      q.push_back(e);
      @(posedge clk);
   endtask

   // three grants on channel ch, each answered one cycle later, period 3
   task automatic rotation(input int o, input logic [NB-1:0] ch);
      step(1, 0, 3, ch, ch, 4'h0, o, 1, 1, 0);
      step(1, 0, 3, ch, ch, ch,   o, 1, 1, 0);
      step(1, 0, 3, ch, ch, ch,   o, 0, 1, 0);   // third grant: DRAIN
      step(1, 0, 3, 4'h0, 4'h0, ch, o, 0, 1, 0); // drained: ROTATE
      step(1, 0, 3, 4'h0, 4'h0, 4'h0, (o + 1) % NB, 1, 1, 0);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; enable = 1'b0; period = 8'd3;
      req = '0; gnt = '0; rvalid = '0;
      #3;
      check_all(0, 0, 1, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // leave IDLE, then the basic rotation to offset 1
      step(1, 0, 3, 4'h0, 4'h0, 4'h0, 0, 1, 1, 0);
      rotation(0, 4'b0001);

      // responses held back: offset must stay 1 until the last one returns
      step(1, 0, 3, 4'b0010, 4'b0010, 4'h0, 1, 1, 1, 0);
      step(1, 0, 3, 4'b0010, 4'b0010, 4'h0, 1, 1, 1, 0);
      step(1, 0, 3, 4'b0010, 4'b0010, 4'h0, 1, 0, 1, 0);
      step(1, 0, 3, 4'h0, 4'h0, 4'h0,       1, 0, 1, 0);
      step(1, 0, 3, 4'h0, 4'h0, 4'h0,       1, 0, 1, 0);
      step(1, 0, 3, 4'h0, 4'h0, 4'b0010,    1, 0, 1, 0);
      step(1, 0, 3, 4'h0, 4'h0, 4'b0010,    1, 0, 1, 0);
      step(1, 0, 3, 4'h0, 4'h0, 4'b0010,    1, 0, 1, 0);
      step(1, 0, 3, 4'h0, 4'h0, 4'h0,       2, 1, 1, 0);

      // remaining rotations wrap the offset back to identity
      rotation(2, 4'b0100);
      rotation(3, 4'b1000);

      // enable dropped together with the third grant: stop without rotating
      step(1, 0, 3, 4'b0001, 4'b0001, 4'h0,    0, 1, 1, 0);
      step(1, 0, 3, 4'b0001, 4'b0001, 4'b0001, 0, 1, 1, 0);
      step(0, 0, 3, 4'b0001, 4'b0001, 4'b0001, 0, 0, 1, 0);
      step(0, 0, 3, 4'h0, 4'h0, 4'b0001,       0, 1, 0, 0);
      step(0, 0, 3, 4'h0, 4'h0, 4'h0,          0, 1, 0, 0);

      // outstanding window: 8 in flight closes the gate, responses reopen it
      step(1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 1, 1, 0);
      step(1, 0, 0, 4'hF, 4'hF, 4'h0, 0, 1, 1, 0);
      step(1, 0, 0, 4'hF, 4'hF, 4'h0, 0, 0, 1, 0);
      step(1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0);
      step(1, 0, 0, 4'h0, 4'h0, 4'hF, 0, 1, 1, 0);
      step(1, 0, 0, 4'h0, 4'h0, 4'hF, 0, 1, 1, 0);

      // underflow sets the sticky error; clear drops it and returns to IDLE
      step(1, 0, 0, 4'h0, 4'h0, 4'b0001, 0, 1, 1, 1);
      step(1, 0, 0, 4'h0, 4'h0, 4'h0,    0, 1, 1, 1);
      step(1, 1, 0, 4'h0, 4'h0, 4'h0,    0, 1, 0, 0);
      step(0, 0, 0, 4'h0, 4'h0, 4'h0,    0, 1, 0, 0);

      @(negedge clk);
      enable = 1'b0; clear = 1'b0; req = '0; gnt = '0; rvalid = '0;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
